csi_pkt_scheduler: RTL and testbench

Packet-level round-robin scheduler that shares the single CSI master protocol layer's packet input among N_REQ packet sources, such as per-virtual-channel line generators and a frame-sync short-packet source. It sits upstream of `csi_master_protocol_layer`. It grants one source at a time for a whole packet, passes that source's beats through, and enforces a minimum idle gap between packets so the D-PHY adapter layer can complete its HS exit/entry. It also gates new grants with a link-enable input.

---
 rtl/csi_pkt_sched_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/csi_pkt_scheduler.sv | 173 +++++++++++++++++
 tb/tb_csi_pkt_scheduler.sv | 494 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csi_pkt_sched_pkg.sv
// Shared types and constants for the CSI packet scheduler.
//   sched_state_t : scheduler FSM states (IDLE, GRANT, GAP)
//   GAP_CNT_W     : width of the inter-packet gap counter
package csi_pkt_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } sched_state_t;

  localparam int unsigned GAP_CNT_W = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first asserted request
// searching upward from i_ptr with wrap-around.
// Ports:
//   i_req  [N-1:0]     request vector
//   i_ptr  [IDX_W-1:0] search start index (must be < N)
//   o_gnt  [N-1:0]     one-hot winner, 0 when no request
//   o_id   [IDX_W-1:0] winner index, 0 when no request
//   o_any              at least one request present
module rr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt,
  output logic [IDX_W-1:0] o_id,
  output logic             o_any
);

  always_comb begin
    o_gnt = '0;
    o_id  = '0;
    o_any = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      int unsigned w_idx;
      w_idx = (int'(i_ptr) + k) % N;
      if (!o_any && i_req[w_idx]) begin
        o_any        = 1'b1;
        o_gnt[w_idx] = 1'b1;
        o_id         = IDX_W'(w_idx);
      end
    end
  end

endmodule

// File: rtl/csi_pkt_scheduler.sv
// Packet-level round-robin scheduler feeding the CSI master protocol layer.
// One source is granted for a whole packet; its beats pass through with zero
// latency. After each packet's last beat a GAP_CYCLES idle gap is enforced,
// followed by one IDLE arbitration cycle. New grants require link_en.
// Optional feature macro: CSI_PKT_SCHED_PRIO_EN (requester 0 strict priority).
// Ports:
//   hs_clk, rst (async, active-low)
//   link_en                 gate for new grants (sampled in IDLE only)
//   req_valid/req_data/req_last [per source]  source beats
//   req_ready [N_REQ]       per-source accept
//   out_valid/out_data/out_last, out_ready    muxed stream to protocol layer
//   gnt [N_REQ] one-hot grant, gnt_id grant index, busy (GRANT or GAP)
module csi_pkt_scheduler
  import csi_pkt_sched_pkg::*;
#(
  parameter  int unsigned N_REQ      = 4,
  parameter  int unsigned DATA_W     = 32,
  parameter  int unsigned GAP_CYCLES = 4,
  localparam int unsigned IDX_W      = $clog2(N_REQ)
) (
  input  logic                    hs_clk,
  input  logic                    rst,
  input  logic                    link_en,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    out_valid,
  output logic [DATA_W-1:0]       out_data,
  output logic                    out_last,
  input  logic                    out_ready,
  output logic [N_REQ-1:0]        gnt,
  output logic [IDX_W-1:0]        gnt_id,
  output logic                    busy
);

  localparam logic [GAP_CNT_W-1:0] GAP_LOAD =
    (GAP_CYCLES > 0) ? GAP_CNT_W'(GAP_CYCLES - 1) : '0;

  sched_state_t          r_state, w_state_nxt;
  logic [IDX_W-1:0]      r_rr_ptr, w_rr_ptr_nxt;
  logic [GAP_CNT_W-1:0]  r_gap_cnt, w_gap_cnt_nxt;
  logic [IDX_W-1:0]      r_gnt_id, w_gnt_id_nxt;
  logic [N_REQ-1:0]      r_gnt, w_gnt_nxt;

  logic [N_REQ-1:0]      w_arb_req;
  logic [N_REQ-1:0]      w_arb_gnt;
  logic [IDX_W-1:0]      w_arb_id;
  logic                  w_arb_any;
  logic [IDX_W-1:0]      w_arb_ptr_inc;

  logic                  w_sel_valid;
  logic                  w_sel_last;
  logic [DATA_W-1:0]     w_sel_data;

`ifdef CSI_PKT_SCHED_PRIO_EN
  // Requester 0 is handled outside the arbiter; the rest stay round-robin.
  assign w_arb_req = {req_valid[N_REQ-1:1], 1'b0};
`else
  assign w_arb_req = req_valid;
`endif

  rr_arbiter #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .i_req (w_arb_req),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_arb_gnt),
    .o_id  (w_arb_id),
    .o_any (w_arb_any)
  );

  assign w_arb_ptr_inc = (w_arb_id == IDX_W'(N_REQ - 1)) ? '0 : w_arb_id + 1'b1;

  // Granted source mux.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    w_sel_data  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (r_gnt_id == IDX_W'(i)) begin
        w_sel_valid = req_valid[i];
        w_sel_last  = req_last[i];
        w_sel_data  = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge hs_clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_rr_ptr  <= '0;
      r_gap_cnt <= '0;
      r_gnt_id  <= '0;
      r_gnt     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_rr_ptr  <= w_rr_ptr_nxt;
      r_gap_cnt <= w_gap_cnt_nxt;
      r_gnt_id  <= w_gnt_id_nxt;
      r_gnt     <= w_gnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_rr_ptr_nxt  = r_rr_ptr;
    w_gap_cnt_nxt = r_gap_cnt;
    w_gnt_id_nxt  = r_gnt_id;
    w_gnt_nxt     = r_gnt;
    out_valid     = 1'b0;
    out_data      = '0;
    out_last      = 1'b0;
    req_ready     = '0;
    gnt           = '0;
    gnt_id        = '0;

    unique case (r_state)
      IDLE: begin
`ifdef CSI_PKT_SCHED_PRIO_EN
        if (link_en && req_valid[0]) begin
          w_state_nxt  = GRANT;
          w_gnt_id_nxt = '0;
          w_gnt_nxt    = N_REQ'(1);
        end else if (link_en && w_arb_any) begin
          w_state_nxt  = GRANT;
          w_gnt_id_nxt = w_arb_id;
          w_gnt_nxt    = w_arb_gnt;
          w_rr_ptr_nxt = w_arb_ptr_inc;
        end
`else
        if (link_en && w_arb_any) begin
          w_state_nxt  = GRANT;
          w_gnt_id_nxt = w_arb_id;
          w_gnt_nxt    = w_arb_gnt;
          w_rr_ptr_nxt = w_arb_ptr_inc;
        end
`endif
      end

      GRANT: begin
        out_valid = w_sel_valid;
        out_data  = w_sel_data;
        out_last  = w_sel_last;
        req_ready = out_ready ? r_gnt : '0;
        gnt       = r_gnt;
        gnt_id    = r_gnt_id;
        if (w_sel_valid && out_ready && w_sel_last) begin
          if (GAP_CYCLES == 0) begin
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt   = GAP;
            w_gap_cnt_nxt = GAP_LOAD;
          end
        end
      end

      GAP: begin
        if (r_gap_cnt == '0) begin
          w_state_nxt = IDLE;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt - 1'b1;
        end
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  assign busy = (r_state != IDLE);

endmodule

// File: tb/tb_csi_pkt_scheduler.sv
// Self-checking bench for csi_pkt_scheduler (N_REQ=4, DATA_W=32, GAP_CYCLES=4).
module tb_csi_pkt_scheduler;

  localparam int N   = 4;
  localparam int W   = 32;
  localparam int GAP = 4;

  logic           hs_clk = 1'b0;
  logic           rst;
  logic           link_en;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_last;
  logic           out_ready;
  logic [N-1:0]   gnt;
  logic [1:0]     gnt_id;
  logic           busy;

  always #5 hs_clk = ~hs_clk;

  csi_pkt_scheduler #(
    .N_REQ      (N),
    .DATA_W     (W),
    .GAP_CYCLES (GAP)
  ) dut (
    .hs_clk    (hs_clk),
    .rst       (rst),
    .link_en   (link_en),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .busy      (busy)
  );

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- packet sources ----------------
  bit s_act [N];
  int s_len [N];
  int s_idx [N];
  int s_pkt [N];
  bit s_rep [N];
  bit s_ven [N];
  bit rand_mode = 1'b0;
  int fired_total = 0;

  function automatic logic [31:0] mk(input int i, input int p, input int k);
    logic [31:0] v;
    v = {i[3:0], p[11:0], k[15:0]};
    return v;
  endfunction

  task automatic drive_src();
    for (int i = 0; i < N; i++) begin
      req_valid[i]       = s_act[i] && s_ven[i];
      req_last[i]        = s_act[i] && (s_idx[i] == s_len[i] - 1);
      req_data[i*W +: W] = s_act[i] ? mk(i, s_pkt[i], s_idx[i]) : '0;
    end
  endtask

  task automatic load_pkt(input int i, input int len);
    s_act[i] = 1'b1;
    s_len[i] = len;
    s_idx[i] = 0;
    s_ven[i] = 1'b1;
    drive_src();
  endtask

  initial begin : src_proc
    logic [N-1:0] f;
    forever begin
      @(posedge hs_clk);
      f = req_valid & req_ready;
      #1;
      for (int i = 0; i < N; i++) begin
        if (f[i]) begin
          fired_total++;
          s_idx[i]++;
          if (s_idx[i] == s_len[i]) begin
            s_act[i] = 1'b0;
            s_pkt[i]++;
            if (s_rep[i]) begin
              s_act[i] = 1'b1;
              s_idx[i] = 0;
            end
          end
        end
        if (rand_mode) begin
          if (!s_act[i] && ($urandom % 4 == 0)) begin
            s_act[i] = 1'b1;
            s_len[i] = int'($urandom_range(1, 4));
            s_idx[i] = 0;
          end
          s_ven[i] = ($urandom % 4 != 0);
        end
      end
      drive_src();
    end
  end

  // ---------------- behavioural model ----------------
  // Owner = source holding the link (-1 none); m_gap = idle cycles still owed.
  int m_owner = -1;
  int m_gap   = 0;
  int m_ptr   = 0;

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_gap   = 0;
    m_ptr   = 0;
  endtask

  task automatic model_step();
    if (m_owner < 0 && m_gap == 0) begin
      if (link_en && req_valid != '0) begin
`ifdef CSI_PKT_SCHED_PRIO_EN
        if (req_valid[0]) begin
          m_owner = 0;
        end else begin
          m_owner = pick(req_valid, m_ptr);
          m_ptr   = (m_owner + 1) % N;
        end
`else
        m_owner = pick(req_valid, m_ptr);
        m_ptr   = (m_owner + 1) % N;
`endif
      end
    end else if (m_owner >= 0) begin
      if (req_valid[m_owner] && out_ready && req_last[m_owner]) begin
        m_owner = -1;
        m_gap   = GAP;
      end
    end else begin
      m_gap--;
    end
  endtask

  initial begin : model_proc
    forever begin
      @(posedge hs_clk);
      if (rst === 1'b1) model_step();
    end
  end

  // ---------------- compare + logging ----------------
  int          dut_grants[$];
  int          beat_src[$];
  logic [31:0] beat_data[$];
  bit          beat_last[$];

  initial begin : cmp_proc
    logic [N-1:0] eg;
    logic [N-1:0] er;
    bit prev_g;
    prev_g = 1'b0;
    forever begin
      @(negedge hs_clk);
      if (rst === 1'b1) begin
        eg = '0;
        er = '0;
        if (m_owner >= 0) begin
          eg[m_owner] = 1'b1;
          if (out_ready) er[m_owner] = 1'b1;
        end
        chk("busy", busy, (m_owner >= 0) || (m_gap > 0));
        chk("gnt", gnt, eg);
        chk("gnt_id", gnt_id, (m_owner >= 0) ? m_owner : 0);
        chk("out_valid", out_valid, (m_owner >= 0) ? req_valid[m_owner] : 1'b0);
        chk("req_ready", req_ready, er);
        if (m_owner >= 0) begin
          chk("out_last", out_last, req_last[m_owner]);
          chk("out_data", out_data, req_data[m_owner*W +: W]);
        end else begin
          chk("out_last_idle", out_last, 0);
        end
        if (gnt != '0 && !prev_g) dut_grants.push_back(int'(gnt_id));
        prev_g = (gnt != '0);
        if (out_valid && out_ready) begin
          beat_src.push_back(int'(gnt_id));
          beat_data.push_back(out_data);
          beat_last.push_back(out_last);
        end
      end else begin
        prev_g = 1'b0;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge hs_clk);
    #2;
  endtask

  task automatic clear_srcs();
    for (int i = 0; i < N; i++) begin
      s_act[i] = 1'b0; s_len[i] = 0; s_idx[i] = 0;
      s_pkt[i] = 0;    s_rep[i] = 1'b0; s_ven[i] = 1'b1;
    end
    drive_src();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    rand_mode = 1'b0;
    clear_srcs();
    link_en   = 1'b1;
    out_ready = 1'b1;
    dut_grants.delete();
    beat_src.delete();
    beat_data.delete();
    beat_last.delete();
    fired_total = 0;
    repeat (2) @(posedge hs_clk);
    #2 rst = 1'b1;
  endtask

  function automatic bit any_src();
    bit a;
    a = 1'b0;
    for (int i = 0; i < N; i++) a |= s_act[i];
    return a;
  endfunction

  task automatic wait_idle(input int maxc, input string name);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < maxc; c++) begin
      @(negedge hs_clk);
      if (!busy && !any_src()) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, ok, 1);
  endtask

  task automatic wait_grants(input int n, input int maxc, input string name);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < maxc; c++) begin
      @(negedge hs_clk);
      if (dut_grants.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, ok, 1);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
    $fatal(1);
  end

  // ---------------- directed + random sequence ----------------
  initial begin : main
    bit found;
    bit r;
    bit hv;
    logic [31:0] held;
    int exp_b[5];
    int exp_f[4];

    rst = 1'b0;
    link_en = 1'b1;
    out_ready = 1'b1;
    clear_srcs();
    repeat (2) @(posedge hs_clk);
    @(negedge hs_clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_gnt_id", gnt_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_out_data", out_data, 0);
    do_reset();

    // A: single source, 3 beats, gap and next-grant spacing
    step();
    load_pkt(2, 3);
    @(negedge hs_clk);
    chk("A_gnt_idle", gnt, 4'b0000);
    @(negedge hs_clk);
    chk("A_gnt", gnt, 4'b0100);
    chk("A_data0", out_data, mk(2, 0, 0));
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (out_valid && out_ready && out_last) found = 1'b1;
      else @(negedge hs_clk);
    end
    chk("A_last_seen", found, 1);
    #2 load_pkt(1, 1);
    for (int k = 0; k < GAP; k++) begin
      @(negedge hs_clk);
      chk("A_gap_busy", busy, 1);
      chk("A_gap_gnt", gnt, 4'b0000);
    end
    @(negedge hs_clk);
    chk("A_idle_busy", busy, 0);
    chk("A_idle_gnt", gnt, 4'b0000);
    @(negedge hs_clk);
    chk("A_next_gnt", gnt, 4'b0010);
    wait_idle(40, "A_drain");
    chk("A_beats", beat_src.size(), 4);
    if (beat_src.size() >= 3) begin
      for (int k = 0; k < 3; k++) begin
        chk("A_beat_src", beat_src[k], 2);
        chk("A_beat_data", beat_data[k], mk(2, 0, k));
        chk("A_beat_last", beat_last[k], (k == 2));
      end
    end

    // B: all four requesting 1-beat packets continuously
`ifdef CSI_PKT_SCHED_PRIO_EN
    exp_b = '{0, 0, 0, 0, 0};
`else
    exp_b = '{0, 1, 2, 3, 0};
`endif
    do_reset();
    for (int i = 0; i < N; i++) begin
      s_rep[i] = 1'b1;
      load_pkt(i, 1);
    end
    wait_grants(5, 200, "B_grant_timeout");
    for (int k = 0; k < 5; k++) begin
      if (k < dut_grants.size()) chk("B_order", dut_grants[k], exp_b[k]);
    end
    for (int i = 0; i < N; i++) s_rep[i] = 1'b0;
    wait_idle(200, "B_drain");

    // C: backpressure with out_ready toggling
    do_reset();
    load_pkt(3, 4);
    r = 1'b1;
    hv = 1'b0;
    held = '0;
    for (int c = 0; c < 24; c++) begin
      step();
      out_ready = r;
      r = !r;
      @(negedge hs_clk);
      if (hv) begin
        chk("C_hold", out_data, held);
        hv = 1'b0;
      end
      if (gnt != '0) begin
        chk("C_rdy_mirror", req_ready, out_ready ? 4'b1000 : 4'b0000);
        if (!out_ready) begin
          held = out_data;
          hv = 1'b1;
        end
      end
    end
    step();
    out_ready = 1'b1;
    wait_idle(40, "C_drain");
    chk("C_beats", beat_src.size(), 4);
    if (beat_src.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        chk("C_beat_data", beat_data[k], mk(3, 0, k));
        chk("C_beat_last", beat_last[k], (k == 3));
      end
    end

    // D: link enable gating
    do_reset();
    step();
    link_en = 1'b0;
    load_pkt(1, 2);
    load_pkt(3, 2);
    repeat (5) @(negedge hs_clk);
    chk("D_no_gnt", gnt, 4'b0000);
    chk("D_no_busy", busy, 0);
    step();
    link_en = 1'b1;
    @(negedge hs_clk);
    @(negedge hs_clk);
    chk("D_gnt_id", gnt_id, 1);
    step();
    link_en = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge hs_clk);
      if (!s_act[1]) found = 1'b1;
    end
    chk("D_pkt_done", found, 1);
    repeat (12) @(negedge hs_clk);
    chk("D_hold_gnt", gnt, 4'b0000);
    chk("D_hold_busy", busy, 0);
    chk("D_grant_count", dut_grants.size(), 1);
    chk("D_beats", beat_src.size(), 2);
    step();
    link_en = 1'b1;
    wait_idle(40, "D_drain");

    // E: reset in the middle of a 5-beat packet
    do_reset();
    load_pkt(0, 5);
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge hs_clk);
      if (s_idx[0] >= 1) found = 1'b1;
    end
    chk("E_beat2_seen", found, 1);
    #2 rst = 1'b0;
    model_reset();
    #1;
    chk("E_rst_valid", out_valid, 0);
    chk("E_rst_gnt", gnt, 4'b0000);
    chk("E_rst_busy", busy, 0);
    chk("E_rst_ready", req_ready, 4'b0000);
    do_reset();
    step();
    load_pkt(0, 1);
    load_pkt(3, 1);
    @(negedge hs_clk);
    @(negedge hs_clk);
    chk("E_first_after_rst", gnt_id, 0);
    wait_idle(60, "E_drain");

    // F: sources 0 and 2 requesting continuously
`ifdef CSI_PKT_SCHED_PRIO_EN
    exp_f = '{0, 0, 0, 0};
`else
    exp_f = '{0, 2, 0, 2};
`endif
    do_reset();
    s_rep[0] = 1'b1;
    s_rep[2] = 1'b1;
    load_pkt(0, 1);
    load_pkt(2, 1);
    wait_grants(4, 200, "F_grant_timeout");
    for (int k = 0; k < 4; k++) begin
      if (k < dut_grants.size()) chk("F_order", dut_grants[k], exp_f[k]);
    end
    s_rep[0] = 1'b0;
    s_rep[2] = 1'b0;
    wait_idle(200, "F_drain");

    // R: randomized traffic against the model
    do_reset();
    rand_mode = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      step();
      out_ready = ($urandom % 4 != 0);
      link_en   = ($urandom % 16 != 0);
    end
    step();
    rand_mode = 1'b0;
    for (int i = 0; i < N; i++) s_ven[i] = 1'b1;
    drive_src();
    link_en   = 1'b1;
    out_ready = 1'b1;
    wait_idle(400, "R_drain");
    chk("R_beat_count", beat_src.size(), fired_total);
    chk("R_activity", dut_grants.size() > 50, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
